// File: rtl/display_scan_ctrl_if.sv
// Digit write channel for the display scan controller.
// Transfer happens on wr_valid & wr_ready at a clock edge.
interface display_scan_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [4:0] wr_code;
  logic       wr_par;

  modport master (
    output wr_valid, wr_addr, wr_code, wr_par,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_code, wr_par,
    output wr_ready
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner with shadow/active banks.
// Feeds a shared 7-seg decoder, tracks sticky per-digit parity errors.
module display_scan_ctrl #(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               err_clr,
  display_scan_ctrl_if.slave wr,
  output logic [4:0]         dec_code,
  output logic               dec_par,
  output logic [3:0]         dig_sel,
  output logic [3:0]         err_flag,
  output logic               frame_done
);

  localparam int CMAX =
    (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW =
    (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] SHOW_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYC - 1);
  localparam logic [5:0] BLANK_ENT = 6'b110000;

  typedef enum logic [1:0] {
    IDLE, COPY, SHOW, BLANK
  } state_t;

  state_t        state, state_d;
  logic [1:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;

  logic [5:0] shadow [4];
  logic [5:0] active [4];
  logic [5:0] act_sel;
  logic [5:0] ent_d;
  logic [3:0] sel_d;
  logic [3:0] err_d;
  logic       fd_d;
  logic       rdy_d;
  logic       wr_fire;
  logic       wr_bad;

  assign wr_fire = wr.wr_valid & wr.wr_ready;
  assign wr_bad  = ^{wr.wr_code, wr.wr_par};

  // State, digit index and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
    end
  end

  // Scan sequencing; en low always wins.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: state_d = COPY;
        COPY: begin
          state_d = SHOW;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_d = '0;
            if (idx == 2'd3) begin
              state_d = COPY;
              idx_d   = 2'd0;
            end else begin
              state_d = SHOW;
              idx_d   = idx + 2'd1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Next output values, aligned with the state being entered.
  always_comb begin
    act_sel = (state == COPY) ? shadow[idx_d]
                              : active[idx_d];
    sel_d   = 4'b0000;
    ent_d   = BLANK_ENT;
    if (state_d == SHOW) begin
      sel_d = 4'b0001 << idx_d;
      ent_d = act_sel;
    end
    fd_d  = (state == BLANK) && (state_d == COPY);
    rdy_d = (state_d != COPY);
  end

  // Sticky parity flags; a new error beats a clear.
  always_comb begin
    err_d = err_clr ? 4'b0000 : err_flag;
    if (wr_fire && wr_bad) begin
      err_d[wr.wr_addr] = 1'b1;
    end
  end

  // Shadow takes writes, active reloads once per COPY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= BLANK_ENT;
        active[i] <= BLANK_ENT;
      end
    end else begin
      if (state == COPY) begin
        for (int i = 0; i < 4; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (wr_fire) begin
        shadow[wr.wr_addr] <= {wr.wr_code, wr.wr_par};
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_sel     <= 4'b0000;
      dec_code    <= BLANK_ENT[5:1];
      dec_par     <= BLANK_ENT[0];
      frame_done  <= 1'b0;
      wr.wr_ready <= 1'b1;
      err_flag    <= 4'b0000;
    end else begin
      dig_sel     <= sel_d;
      dec_code    <= ent_d[5:1];
      dec_par     <= ent_d[0];
      frame_done  <= fd_d;
      wr.wr_ready <= rdy_d;
      err_flag    <= err_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model,
// directed scenarios and a long randomized run.
module tb_display_scan_ctrl;

  localparam int S     = 4;
  localparam int B     = 2;
  localparam int FRAME = 1 + 4 * (S + B);
  localparam logic [5:0] BLANK_ENT = 6'b110000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       err_clr = 1'b0;
  logic [4:0] dec_code;
  logic       dec_par;
  logic [3:0] dig_sel;
  logic [3:0] err_flag;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  display_scan_ctrl_if wr_if ();

  display_scan_ctrl #(
    .SCAN_DIV  (S),
    .BLANK_CYC (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .err_clr    (err_clr),
    .wr         (wr_if),
    .dec_code   (dec_code),
    .dec_par    (dec_par),
    .dig_sel    (dig_sel),
    .err_flag   (err_flag),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: running flag plus position within the frame.
  bit         run = 1'b0;
  int         pos = 0;
  bit         m_fd = 1'b0;
  logic [3:0] m_err = 4'b0;
  logic [5:0] m_shadow [4];
  logic [5:0] m_active [4];
  logic       m_copy;
  logic       m_rdy;

  assign m_copy = run && (pos == 0);
  assign m_rdy  = !m_copy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      pos   <= 0;
      m_fd  <= 1'b0;
      m_err <= 4'b0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] <= BLANK_ENT;
        m_active[i] <= BLANK_ENT;
      end
    end else begin
      if (m_copy) begin
        for (int i = 0; i < 4; i++) m_active[i] <= m_shadow[i];
      end
      m_err <= (err_clr ? 4'b0 : m_err) |
               ((wr_if.wr_valid && m_rdy &&
                 ^{wr_if.wr_code, wr_if.wr_par})
                  ? (4'b0001 << wr_if.wr_addr) : 4'b0);
      if (wr_if.wr_valid && m_rdy)
        m_shadow[wr_if.wr_addr] <= {wr_if.wr_code, wr_if.wr_par};
      m_fd <= en && run && (pos == FRAME - 1);
      run  <= en;
      pos  <= (!en || !run) ? 0 : (pos + 1) % FRAME;
    end
  end

  logic [3:0] e_sel;
  logic [5:0] e_ent;

  always_comb begin
    int q, d, r;
    q = pos - 1;
    d = (q < 0) ? 0 : q / (S + B);
    r = (q < 0) ? 0 : q % (S + B);
    e_sel = 4'b0000;
    e_ent = BLANK_ENT;
    if (run && pos > 0 && r < S) begin
      e_sel = 4'b0001 << d;
      e_ent = m_active[d];
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (go) begin
      chk("dig_sel", dig_sel, e_sel);
      chk("dec", {dec_code, dec_par}, e_ent);
      chk("wr_ready", wr_if.wr_ready, m_rdy);
      chk("err_flag", err_flag, m_err);
      chk("frame_done", frame_done, m_fd);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a,
                          input logic [4:0] c,
                          input logic p);
    int n;
    n = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_code  = c;
    wr_if.wr_par   = p;
    while (!wr_if.wr_ready && n < 10) begin
      tick;
      n++;
    end
    chk("wr_accept_timeout", n < 10, 1);
    tick;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_sel(input logic [3:0] v, output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (dig_sel !== v && n < 200);
    chk("wait_sel_timeout", dig_sel == v, 1);
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    chk("wait_fd_timeout", frame_done, 1);
  endtask

  initial begin
    int n;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 2'd0;
    wr_if.wr_code  = 5'd0;
    wr_if.wr_par   = 1'b0;
    tick;
    tick;
    chk("rst_dig_sel", dig_sel, 4'b0000);
    chk("rst_dec_code", dec_code, 5'b11000);
    chk("rst_dec_par", dec_par, 0);
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_err_flag", err_flag, 4'b0000);
    chk("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    go = 1'b1;
    tick;

    // Write in IDLE, then start scanning.
    do_write(2'd2, 5'b00111, 1'b1);
    en = 1'b1;
    wait_sel(4'b0100, n);
    chk("first_dig2_latency", n, 14);
    chk("dig2_code", {dec_code, dec_par}, 6'b001111);
    chk("no_err", err_flag, 4'b0000);

    // Frame period.
    wait_fd(n);
    wait_fd(n);
    chk("frame_period", n, FRAME);

    // Mid-frame write only shows after the next frame boundary.
    wait_sel(4'b0010, n);
    do_write(2'd0, 5'b00101, 1'b1);
    wait_fd(n);
    wait_sel(4'b0001, n);
    chk("midframe_dig0", {dec_code, dec_par}, 6'b001011);

    // Sticky error flags.
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("err_clr0", err_flag, 4'b0000);
    do_write(2'd1, 5'b00011, 1'b1);
    chk("err_set1", err_flag, 4'b0010);
    err_clr = 1'b1;
    do_write(2'd1, 5'b00011, 1'b1);
    err_clr = 1'b0;
    chk("err_set_wins", err_flag, 4'b0010);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("err_clr1", err_flag, 4'b0000);

    // Write held across COPY.
    wait_fd(n);
    chk("copy_not_ready", wr_if.wr_ready, 0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 2'd3;
    wr_if.wr_code  = 5'b10101;
    wr_if.wr_par   = 1'b1;
    tick;
    chk("ready_after_copy", wr_if.wr_ready, 1);
    tick;
    wr_if.wr_valid = 1'b0;
    wait_fd(n);
    wait_sel(4'b1000, n);
    chk("held_write_dig3", {dec_code, dec_par}, 6'b101011);

    // Drop enable during digit 2, then restart.
    wait_sel(4'b0100, n);
    en = 1'b0;
    tick;
    chk("en_drop_sel", dig_sel, 4'b0000);
    chk("en_drop_ready", wr_if.wr_ready, 1);
    en = 1'b1;
    tick;
    chk("restart_copy", wr_if.wr_ready, 0);
    chk("restart_no_fd", frame_done, 0);
    tick;
    chk("restart_dig0", dig_sel, 4'b0001);

    // Randomized run.
    for (int k = 0; k < 3000; k++) begin
      en             = ($urandom_range(0, 99) != 0);
      err_clr        = ($urandom_range(0, 19) == 0);
      wr_if.wr_valid = ($urandom_range(0, 9) < 3);
      wr_if.wr_addr  = 2'($urandom_range(0, 3));
      wr_if.wr_code  = 5'($urandom_range(0, 31));
      wr_if.wr_par   = 1'($urandom_range(0, 1));
      rst_n          = ($urandom_range(0, 299) != 0);
      tick;
      rst_n = 1'b1;
    end

    en = 1'b0;
    wr_if.wr_valid = 1'b0;
    err_clr = 1'b0;
    tick;
    tick;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, 4, cycles each digit is shown (>=1).
REQ-002 SHALL have parameter BLANK_CYC, 2, all-off cycles between digits (>=1).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  scan enable.
REQ-007 wr_valid  in  1  digit write request.
REQ-008 wr_ready  out  1  write accept; transfer on wr_valid&wr_ready at clk edge.
REQ-009 wr_addr  in  2  target digit 0..3.
REQ-010 wr_code  in  5  digit code, bit4=b1 (MSB) .. bit0=b5.
REQ-011 wr_par  in  1  parity bit accompanying wr_code.
REQ-012 err_clr  in  1  clears all err_flag bits.
REQ-013 dec_code  out  5  code to shared 7-seg decoder (b1..b5).
REQ-014 dec_par  out  1  parity to shared decoder.
REQ-015 dig_sel  out  4  one-hot digit enable, active high.
REQ-016 err_flag  out  4  sticky per-digit parity error.
REQ-017 frame_done  out  1  one-cycle pulse at frame boundary.

Function
REQ-018 SHALL hold 4 shadow and 4 active entries of {code[4:0],par}; blank entry = {5'b11000,0}.
REQ-019 Accepted write SHALL update shadow[wr_addr] only; active bank changes only in COPY.
REQ-020 FSM states IDLE, COPY, SHOW, BLANK; digit index idx 0..3.
REQ-021 IDLE -> COPY when en=1; stays IDLE otherwise.
REQ-022 COPY lasts 1 cycle: active <= shadow at its ending edge; then SHOW with idx=0.
REQ-023 SHOW lasts exactly SCAN_DIV cycles, then BLANK.
REQ-024 BLANK lasts exactly BLANK_CYC cycles; then SHOW with idx+1 if idx<3, else COPY (idx wraps to 0).
REQ-025 en=0 in any state SHALL force IDLE at next edge, idx=0, cycle counter cleared.
REQ-026 Enabled frame period SHALL be 1+4*(SCAN_DIV+BLANK_CYC) cycles.
REQ-027 SHOW: dig_sel=one-hot(idx), {dec_code,dec_par}=active[idx].
REQ-028 IDLE, COPY, BLANK: dig_sel=4'b0000, {dec_code,dec_par}=blank entry.
REQ-029 wr_ready=0 in COPY, 1 in all other states; COPY never loses a write.
REQ-030 Parity even over 6 bits: error when XOR(wr_code,wr_par)=1.
REQ-031 Accepted write with parity error SHALL set err_flag[wr_addr]; good-parity writes do not clear it.
REQ-032 err_clr clears all bits next edge; set and clear same cycle -> set wins for that bit.
REQ-033 Bad-parity writes still stored; shared decoder shows its error pattern.
REQ-034 frame_done=1 for the single cycle in COPY entered from BLANK; 0 on COPY from IDLE.
REQ-035 All outputs registered; cycle counter width covers max(SCAN_DIV,BLANK_CYC).

Reset
REQ-036 rst_n=0 SHALL immediately set: state IDLE, idx=0, counter=0, all shadow/active=blank entry, err_flag=0, dig_sel=0, dec_code=5'b11000, dec_par=0, frame_done=0, wr_ready=1.
REQ-037 Reset mid-frame SHALL discard shadow contents and pending display; first frame after release starts from COPY.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-038 Reset, en=1, no writes -> dig_sel 0001,0010,0100,1000 each 4 cycles, 2 zero cycles between; dec_code=11000 throughout; frame_done every 25 cycles.
REQ-039 In IDLE write addr2 code 00111 par 1, then en=1 -> digit 2 shows 00111/1 first frame; err_flag=0000.
REQ-040 Mid-frame write addr0 code 00101 par 1 -> digit 0 unchanged until after next frame_done, then 00101/1.
REQ-041 Write addr1 code 00011 par 1 -> err_flag=0010; err_clr with concurrent bad write addr1 -> err_flag stays 0010; err_clr alone -> 0000.
REQ-042 wr_valid held high across COPY -> wr_ready=0 that cycle, write accepted next cycle, no data lost.
REQ-043 en dropped during SHOW idx=2 -> next cycle dig_sel=0000, IDLE; re-enable restarts at COPY, idx=0.
